settle_monitor_fp_int: RTL and testbench

//  Downstream consumer of the fixed-point integrator state output (7-bit `out`).
//  - Measures how many update strobes the output takes to settle into a tolerance band around a target code.
//  - Tracks peak overshoot.
//  - Reports one result per measurement over a valid/ready handshake to the bench scoreboard/controller.
//  - Runs on the same clk as the integrator; sample_en marks integrator update cycles.

---
 rtl/settle_pkg.sv | 19 +
 rtl/settle_monitor_fp_int_if.sv | 40 ++++
 rtl/band_check_fp_int.sv | 29 ++
 rtl/settle_monitor_fp_int.sv | 144 ++++++++++++++
 tb/tb_settle_monitor_fp_int.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/settle_pkg.sv
// Shared definitions for the settle monitor.
// Contents: FSM state encoding and default parameter values matching the
// integrator it observes (7-bit output settling toward code 105).
package settle_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StReport = 2'd2
  } state_e;

  localparam int unsigned DefOutW    = 7;
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTarget  = 105;
  localparam int unsigned DefTol     = 2;
  localparam int unsigned DefHold    = 8;
  localparam int unsigned DefTimeout = 4095;

endpackage

// File: rtl/settle_monitor_fp_int_if.sv
// Bus between the settle monitor and its controller/scoreboard.
// Signals:
//   start       controller -> monitor  begin/restart a measurement
//   sample      controller -> monitor  integrator output code
//   sample_en   controller -> monitor  sample is a fresh integrator value
//   res_ready   controller -> monitor  result accepted
//   busy        monitor -> controller  measurement in progress
//   res_valid   monitor -> controller  result available
//   settle_cnt  monitor -> controller  index of first sample of the final in-band streak
//   peak        monitor -> controller  maximum sample seen
//   timed_out   monitor -> controller  measurement ended without settling
// Modports: master (controller side), slave (monitor side).
interface settle_monitor_fp_int_if
  import settle_pkg::*;
#(
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned CNT_W = DefCntW
);

  logic             start;
  logic [OUT_W-1:0] sample;
  logic             sample_en;
  logic             res_ready;
  logic             busy;
  logic             res_valid;
  logic [CNT_W-1:0] settle_cnt;
  logic [OUT_W-1:0] peak;
  logic             timed_out;

  modport master (
    output start, sample, sample_en, res_ready,
    input  busy, res_valid, settle_cnt, peak, timed_out
  );

  modport slave (
    input  start, sample, sample_en, res_ready,
    output busy, res_valid, settle_cnt, peak, timed_out
  );

endinterface

// File: rtl/band_check_fp_int.sv
// Combinational tolerance-band test: in_band = |sample - TARGET| <= TOL.
// Both operands are zero-extended by one bit before subtracting so the
// difference never wraps at either end of the sample range.
// Ports:
//   sample   in  OUT_W  unsigned sample code
//   in_band  out 1      sample lies within TARGET +/- TOL
module band_check_fp_int #(
  parameter int unsigned OUT_W  = 7,
  parameter int unsigned TARGET = 105,
  parameter int unsigned TOL    = 2
) (
  input  logic [OUT_W-1:0] sample,
  output logic             in_band
);

  localparam logic [OUT_W:0] TargetExt = (OUT_W + 1)'(TARGET);
  localparam logic [OUT_W:0] TolExt    = (OUT_W + 1)'(TOL);

  logic [OUT_W:0] diff;
  logic [OUT_W:0] mag;

  always_comb begin
    diff    = {1'b0, sample} - TargetExt;
    // Two's-complement negate when the signed difference is negative.
    mag     = diff[OUT_W] ? (~diff + 1'b1) : diff;
    in_band = (mag <= TolExt);
  end

endmodule

// File: rtl/settle_monitor_fp_int.sv
// Settle monitor for the fixed-point integrator output.
// Counts sample_en strobes until the sample has stayed within the tolerance
// band for HOLD consecutive strobes, tracks the peak sample, and reports the
// result over a valid/ready handshake. Gives up after TIMEOUT strobes.
// Ports:
//   clk    in  clock, all logic on posedge
//   reset  in  synchronous active-high reset
//   bus    slave modport of settle_monitor_fp_int_if (start/sample/sample_en in,
//          busy/res_valid/settle_cnt/peak/timed_out out, res_ready in)
module settle_monitor_fp_int
  import settle_pkg::*;
#(
  parameter int unsigned OUT_W   = DefOutW,
  parameter int unsigned TARGET  = DefTarget,
  parameter int unsigned TOL     = DefTol,
  parameter int unsigned HOLD    = DefHold,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic                    clk,
  input logic                    reset,
  settle_monitor_fp_int_if.slave bus
);

  localparam logic [CNT_W-1:0] HoldCnt    = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] streak_start_q, streak_start_d;
  logic [OUT_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;

  logic             in_band;
  logic [CNT_W-1:0] streak_upd;
  logic [CNT_W-1:0] start_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic [OUT_W-1:0] peak_upd;

  band_check_fp_int #(
    .OUT_W  (OUT_W),
    .TARGET (TARGET),
    .TOL    (TOL)
  ) u_band_check (
    .sample  (bus.sample),
    .in_band (in_band)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    streak_d       = streak_q;
    streak_start_d = streak_start_q;
    peak_d         = peak_q;
    settle_cnt_d   = settle_cnt_q;
    timed_out_d    = timed_out_q;

    // Candidate values for a sample_en cycle in TRACK.
    streak_upd = in_band ? (streak_q + 1'b1) : '0;
    start_upd  = (in_band && (streak_q == '0)) ? cnt_q : streak_start_q;
    cnt_upd    = cnt_q + 1'b1;
    peak_upd   = (bus.sample > peak_q) ? bus.sample : peak_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d        = StTrack;
          cnt_d          = '0;
          streak_d       = '0;
          streak_start_d = '0;
          peak_d         = '0;
        end
      end
      StTrack: begin
        if (bus.start) begin
          // Restart; the concurrent sample belongs to the abandoned run.
          cnt_d          = '0;
          streak_d       = '0;
          streak_start_d = '0;
          peak_d         = '0;
        end else if (bus.sample_en) begin
          peak_d         = peak_upd;
          streak_d       = streak_upd;
          streak_start_d = start_upd;
          cnt_d          = cnt_upd;
          // Settling takes priority over timeout on the same strobe.
          if (streak_upd == HoldCnt) begin
            state_d      = StReport;
            settle_cnt_d = start_upd;
            timed_out_d  = 1'b0;
          end else if (cnt_upd == TimeoutCnt) begin
            state_d      = StReport;
            settle_cnt_d = TimeoutCnt;
            timed_out_d  = 1'b1;
          end
        end
      end
      StReport: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d == StTrack);
    res_valid_d = (state_d == StReport);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      streak_q       <= '0;
      streak_start_q <= '0;
      peak_q         <= '0;
      settle_cnt_q   <= '0;
      timed_out_q    <= 1'b0;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      streak_q       <= streak_d;
      streak_start_q <= streak_start_d;
      peak_q         <= peak_d;
      settle_cnt_q   <= settle_cnt_d;
      timed_out_q    <= timed_out_d;
      busy_q         <= busy_d;
      res_valid_q    <= res_valid_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.settle_cnt = settle_cnt_q;
  assign bus.peak       = peak_q;
  assign bus.timed_out  = timed_out_q;

endmodule

// File: tb/tb_settle_monitor_fp_int.sv
// Directed bench for settle_monitor_fp_int with a result scoreboard.
module tb_settle_monitor_fp_int;

  typedef struct packed {
    logic [15:0] settle_cnt;
    logic [6:0]  peak;
    logic        timed_out;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  settle_monitor_fp_int_if bus ();

  settle_monitor_fp_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [6:0] val);
    bus.sample    = val;
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
  endtask

  task automatic do_start(input string tag);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head, accept it.
  task automatic get_result(input string tag, input int budget);
    exp_t x;
    int   n;
    n = 0;
    while (!bus.res_valid && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, "_settle"}, 32'(bus.settle_cnt), 32'(x.settle_cnt));
      chk({tag, "_peak"}, 32'(bus.peak), 32'(x.peak));
      chk({tag, "_tout"}, 32'(bus.timed_out), 32'(x.timed_out));
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    clk           = 1'b0;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.sample_en = 1'b1;
    bus.sample    = 7'd105;
    bus.res_ready = 1'b0;

    // 1: reset held 3 cycles with start and sample_en asserted
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_settle", 32'(bus.settle_cnt), 32'd0);
    chk("rst_peak", 32'(bus.peak), 32'd0);
    chk("rst_tout", 32'(bus.timed_out), 32'd0);
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.sample_en = 1'b0;
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // 2: ramp 0..100 then 104 x8; settles on the 19th strobe
    sb.push_back('{settle_cnt: 16'd11, peak: 7'd104, timed_out: 1'b0});
    do_start("t2");
    for (int i = 0; i <= 10; i++) strobe(7'(i * 10));
    for (int i = 0; i < 7; i++) strobe(7'd104);
    chk("t2_early", 32'(bus.res_valid), 32'd0);
    strobe(7'd104);
    get_result("t2", 0);

    // 3: streak broken by an overshoot to 110
    sb.push_back('{settle_cnt: 16'd6, peak: 7'd110, timed_out: 1'b0});
    do_start("t3");
    for (int i = 0; i < 5; i++) strobe(7'd104);
    strobe(7'd110);
    for (int i = 0; i < 8; i++) strobe(7'd106);
    get_result("t3", 0);

    // 4: never settles; times out after 4095 strobes on alternate cycles
    sb.push_back('{settle_cnt: 16'd4095, peak: 7'd50, timed_out: 1'b1});
    do_start("t4");
    for (int i = 0; i < 4095; i++) begin
      strobe(7'd50);
      if (i == 4093) chk("t4_early", 32'(bus.res_valid), 32'd0);
      if (i < 4094) step();
    end
    chk("t4_valid", 32'(bus.res_valid), 32'd1);
    e = sb.pop_front();
    chk("t4_settle", 32'(bus.settle_cnt), 32'(e.settle_cnt));
    chk("t4_tout", 32'(bus.timed_out), 32'(e.timed_out));

    // 5: backpressure with start pulses; result must hold, no restart
    for (int k = 0; k < 10; k++) begin
      bus.start = (k % 2 == 0);
      step();
      chk("t5_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("t5_hold_settle", 32'(bus.settle_cnt), 32'(e.settle_cnt));
      chk("t5_hold_peak", 32'(bus.peak), 32'(e.peak));
      chk("t5_hold_tout", 32'(bus.timed_out), 32'(e.timed_out));
      chk("t5_hold_busy", 32'(bus.busy), 32'd0);
    end
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    chk("t5_drop", 32'(bus.res_valid), 32'd0);
    chk("t5_acc_busy", 32'(bus.busy), 32'd0);
    step();
    chk("t5_no_start", 32'(bus.busy), 32'd0);
    do_start("t5");

    // 6: reset mid-measurement abandons it
    for (int i = 0; i < 5; i++) strobe(7'd105);
    chk("t6_track", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_rst_peak", 32'(bus.peak), 32'd0);
    chk("t6_rst_settle", 32'(bus.settle_cnt), 32'd0);
    repeat (3) step();
    chk("t6_no_result", 32'(bus.res_valid), 32'd0);
    sb.push_back('{settle_cnt: 16'd0, peak: 7'd105, timed_out: 1'b0});
    do_start("t6");
    for (int i = 0; i < 8; i++) strobe(7'd105);
    get_result("t6", 0);

    // 7: restart in TRACK; concurrent sample (127) must not count toward peak
    sb.push_back('{settle_cnt: 16'd0, peak: 7'd106, timed_out: 1'b0});
    do_start("t7");
    for (int i = 0; i < 3; i++) strobe(7'd104);
    bus.start = 1'b1;
    strobe(7'd127);
    bus.start = 1'b0;
    chk("t7_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) strobe(7'd106);
    get_result("t7", 0);

    // 8: band edges (102/108 out, 103/107 in) and range extremes without wrap
    sb.push_back('{settle_cnt: 16'd4, peak: 7'd127, timed_out: 1'b0});
    do_start("t8");
    strobe(7'd102);
    strobe(7'd108);
    strobe(7'd127);
    strobe(7'd0);
    for (int i = 0; i < 4; i++) begin
      strobe(7'd107);
      strobe(7'd103);
    end
    get_result("t8", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
